// File: rtl/sr_latch_ctrl_pkg.sv
// rtl/sr_latch_ctrl_pkg.sv - shared types and constants for the SR latch controller
//
// Holds the controller state encoding and the set/reset opcode values used by
// requesters and by the pulse driver.
package sr_latch_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        RECOV = 2'd2
    } state_t;

    localparam logic OP_SET = 1'b1;
    localparam logic OP_RST = 1'b0;

endpackage

// File: rtl/sr_latch_ctrl_if.sv
// rtl/sr_latch_ctrl_if.sv - requester/completion bundle for the SR latch controller
//
// Ports (signals):
//   req_valid  [N_REQ]       request pending per requester
//   req_op     [N_REQ]       1 = set, 0 = reset per requester
//   req_idx    [N_REQ*IDXW]  target latch, requester k at [k*IDXW +: IDXW]
//   req_ready  [N_REQ]       one-hot grant
//   done_valid               one-cycle completion strobe
//   done_id    [IDW]         requester that completed
//   done_err                 completion error, qualified by done_valid
// Modports: master = requester side, slave = controller side.
interface sr_latch_ctrl_if #(
    parameter int N_REQ = 4,
    parameter int IDXW  = 3
);
    localparam int IDW = $clog2(N_REQ);

    logic [N_REQ-1:0]      req_valid;
    logic [N_REQ-1:0]      req_op;
    logic [N_REQ*IDXW-1:0] req_idx;
    logic [N_REQ-1:0]      req_ready;
    logic                  done_valid;
    logic [IDW-1:0]        done_id;
    logic                  done_err;

    modport master (
        output req_valid, req_op, req_idx,
        input  req_ready, done_valid, done_id, done_err
    );

    modport slave (
        input  req_valid, req_op, req_idx,
        output req_ready, done_valid, done_id, done_err
    );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick
//
// Ports:
//   req     [N]   request vector
//   ptr     [PW]  last winner; search starts at ptr+1 and wraps
//   grant   [N]   one-hot winner (all zero when no request)
//   gnt_id  [PW]  index of the winner
//   gnt_any       at least one request present
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] gnt_id,
    output logic          gnt_any
);

    logic found;

    // Walk N positions starting just after the previous winner; the first
    // requester seen wins, so the previous winner is considered last.
    always_comb begin
        grant  = '0;
        gnt_id = '0;
        found  = 1'b0;
        for (int i = 1; i <= N; i++) begin
            if (!found && req[(int'(ptr) + i) % N]) begin
                found                        = 1'b1;
                grant[(int'(ptr) + i) % N]   = 1'b1;
                gnt_id                       = PW'((int'(ptr) + i) % N);
            end
        end
        gnt_any = found;
    end

endmodule

// File: rtl/sr_latch_ctrl.sv
// rtl/sr_latch_ctrl.sv - round-robin shared SR latch pulse controller
//
// Optional feature macro: SR_LATCH_CTRL_VERIFY_EN (read back q_in after each
// pulse and flag a mismatch in done_err).
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   bus (slave)       requests, one-hot grant, completion strobe
//   s_out, r_out      set/reset drive to the latch bank (at most one bit high)
//   q_in              latch q feedback (used only with the verify feature)
//   busy              high whenever the FSM is not IDLE
module sr_latch_ctrl
    import sr_latch_ctrl_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int N_LATCH   = 8,
    parameter int IDXW      = 3,
    parameter int PULSE_CYC = 2,
    parameter int RECOV_CYC = 1
) (
    input  logic               clk,
    input  logic               rst,
    sr_latch_ctrl_if.slave     bus,
    output logic [N_LATCH-1:0] s_out,
    output logic [N_LATCH-1:0] r_out,
    input  logic [N_LATCH-1:0] q_in,
    output logic               busy
);

    localparam int IDW  = $clog2(N_REQ);
    localparam int MAXC = (PULSE_CYC > RECOV_CYC) ? PULSE_CYC : RECOV_CYC;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [CW-1:0]   PULSE_LD  = CW'(PULSE_CYC);
    localparam logic [CW-1:0]   RECOV_LD  = CW'(RECOV_CYC);
    localparam logic [CW-1:0]   CNT_ONE   = CW'(1);
    localparam logic [IDXW:0]   LATCH_LIM = (IDXW + 1)'(N_LATCH);

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic [IDW-1:0]    ptr;
    logic [IDW-1:0]    id_q;
    logic              op_q;
    logic [IDXW-1:0]   idx_q;
    logic              err_q;
    logic              done_valid_q;
    logic [IDW-1:0]    done_id_q;
    logic              done_err_q;

    logic [N_REQ-1:0]  grant;
    logic [IDW-1:0]    gnt_id;
    logic              gnt_any;
    logic              accept;
    logic              win_op;
    logic [IDXW-1:0]   win_idx;
    logic              win_in_range;
    logic              verify_miss;

    rr_arbiter #(.N(N_REQ), .PW(IDW)) u_arb (
        .req     (bus.req_valid),
        .ptr     (ptr),
        .grant   (grant),
        .gnt_id  (gnt_id),
        .gnt_any (gnt_any)
    );

    assign win_op       = bus.req_op[gnt_id];
    assign win_idx      = bus.req_idx[int'(gnt_id) * IDXW +: IDXW];
    assign win_in_range = ({1'b0, win_idx} < LATCH_LIM);

`ifdef SR_LATCH_CTRL_VERIFY_EN
    logic q_sel;

    always_comb begin
        q_sel = 1'b0;
        for (int i = 0; i < N_LATCH; i++) begin
            if (IDXW'(i) == idx_q) q_sel = q_in[i];
        end
    end

    // Sampled on the first recovery cycle, after the pulse has had time to
    // propagate; range-error transactions never pulsed so they are skipped.
    assign verify_miss = (state == RECOV) && (cnt == RECOV_LD) &&
                         ({1'b0, idx_q} < LATCH_LIM) && (q_sel != op_q);
`else
    logic unused_q_in;
    assign unused_q_in = ^q_in;
    assign verify_miss = 1'b0;
`endif

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        accept        = 1'b0;
        bus.req_ready = '0;
        s_out         = '0;
        r_out         = '0;
        case (state)
            IDLE: begin
                bus.req_ready = grant;
                if (gnt_any) begin
                    accept = 1'b1;
                    if (win_in_range) begin
                        state_nxt = PULSE;
                        cnt_nxt   = PULSE_LD;
                    end else begin
                        state_nxt = RECOV;
                        cnt_nxt   = RECOV_LD;
                    end
                end
            end
            PULSE: begin
                // Only the captured latch is driven, and S/R come from op and
                // its complement, so S&R can never overlap.
                for (int i = 0; i < N_LATCH; i++) begin
                    if (IDXW'(i) == idx_q) begin
                        s_out[i] = (op_q == OP_SET);
                        r_out[i] = (op_q == OP_RST);
                    end
                end
                if (cnt == CNT_ONE) begin
                    state_nxt = RECOV;
                    cnt_nxt   = RECOV_LD;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            RECOV: begin
                if (cnt == CNT_ONE) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            ptr          <= IDW'(N_REQ - 1);
            id_q         <= '0;
            op_q         <= 1'b0;
            idx_q        <= '0;
            err_q        <= 1'b0;
            done_valid_q <= 1'b0;
            done_id_q    <= '0;
            done_err_q   <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            err_q        <= err_q | verify_miss;
            // Strobe lands on the first IDLE cycle after recovery.
            done_valid_q <= (state == RECOV) && (cnt == CNT_ONE);
            if ((state == RECOV) && (cnt == CNT_ONE)) begin
                done_id_q  <= id_q;
                done_err_q <= err_q | verify_miss;
            end
            if (accept) begin
                ptr   <= gnt_id;
                id_q  <= gnt_id;
                op_q  <= win_op;
                idx_q <= win_idx;
                err_q <= !win_in_range;
            end
        end
    end

    assign bus.done_valid = done_valid_q;
    assign bus.done_id    = done_id_q;
    assign bus.done_err   = done_err_q;
    assign busy           = (state != IDLE);

endmodule

// File: doc/sr_latch_ctrl.md
# sr_latch_ctrl

Synchronous controller that shares a bank of SR latches between several requesters. It arbitrates round-robin, then drives one set or reset pulse of fixed width onto the selected latch. A recovery gap follows each pulse. The controller guarantees that S and R are never asserted together on any latch, and that only one latch is pulsed at a time. It sits between software/FSM requesters and the `latch` bank, which is instantiated outside this block.

## Interface
Parameters:
- N_REQ, 4, number of requesters (≥2)
- N_LATCH, 8, number of latches in the bank
- IDXW, 3, latch index width; must satisfy 2**IDXW ≥ N_LATCH
- PULSE_CYC, 2, S/R pulse width in cycles (≥1)
- RECOV_CYC, 1, all-low gap after each pulse (≥1)

Ports:
- clk  in  1  single clock; everything is on the rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  N_REQ  request pending, one bit per requester
- req_op  in  N_REQ  1 = set, 0 = reset, per requester
- req_idx  in  N_REQ*IDXW  target latch; requester k uses bits [k*IDXW +: IDXW]
- req_ready  out  N_REQ  one-hot grant; the request is accepted when valid&ready
- s_out  out  N_LATCH  set drive to the latch bank
- r_out  out  N_LATCH  reset drive to the latch bank
- q_in  in  N_LATCH  latch q outputs, fed back
- done_valid  out  1  one-cycle completion strobe
- done_id  out  $clog2(N_REQ)  requester that just completed
- done_err  out  1  completion had an error; qualified by done_valid
- busy  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, PULSE, RECOV.
- IDLE:
  - If any req_valid is high, a round-robin pick starts searching at ptr+1 (wrapping).
  - req_ready is driven combinationally for the winner only, in that cycle.
  - On acceptance, the controller captures id, op and idx, and sets ptr to the winner.
  - If idx < N_LATCH it goes to PULSE; otherwise it goes to RECOV with err_flag=1.
- PULSE:
  - Drives s_out[idx]=op and r_out[idx]=~op; all other bits are 0.
  - Lasts PULSE_CYC cycles, then goes to RECOV.
- RECOV:
  - s_out and r_out are all 0.
  - Lasts RECOV_CYC cycles, then goes to IDLE.
- Completion: on the first IDLE cycle after RECOV, done_valid=1 and done_id/done_err show the captured values. A new grant may occur in that same cycle.
- Invariants:
  - For all i, (s_out[i] & r_out[i]) is 0.
  - popcount(s_out|r_out) ≤ 1.
  - req_ready is 0 outside IDLE and is never more than one-hot.
  - A requester whose valid is held high without a grant keeps its request pending. Fairness: every valid requester is granted within N_REQ transactions.
- Counter: a single down-counter, width $clog2(max(PULSE_CYC,RECOV_CYC)+1), reloaded on each state entry.

## Timing
- Reset values: state=IDLE, ptr=N_REQ-1 (requester 0 wins first), s_out=0, r_out=0, req_ready=0, done_valid=0, done_id=0, done_err=0, busy=0.
- Reset mid-operation: at the edge where rst is sampled, all outputs go to their reset values. The in-flight transaction is dropped and no done is produced.
- Transaction timeline, with acceptance at cycle 0:
  - Pulse occupies cycles 1..PULSE_CYC.
  - Recovery occupies cycles PULSE_CYC+1..PULSE_CYC+RECOV_CYC.
  - done_valid is high at cycle PULSE_CYC+RECOV_CYC+1; with defaults this is cycle 4.
- Out-of-range idx: no pulse, RECOV_CYC gap, done at cycle RECOV_CYC+1.
- Back-to-back throughput: one transaction per PULSE_CYC+RECOV_CYC+1 cycles.

## Configuration
- SR_LATCH_CTRL_VERIFY_EN
  - Defined:
    - In the first RECOV cycle the controller samples q_in[idx]. If the sample differs from op it ORs 1 into err_flag.
    - Out-of-range transactions skip the check.
  - Undefined:
    - There is no sampling, and q_in is unused.
    - done_err reflects the range error only.

## Structure
- Package sr_latch_ctrl_pkg holds:
  - the state enum (IDLE, PULSE, RECOV);
  - the op constants OP_SET=1'b1 and OP_RST=1'b0.
- Sub-module rr_arbiter (parameter N) contains the combinational round-robin pick from a request vector and ptr. The FSM stays in sr_latch_ctrl.

## Test plan
- After reset, requester 0 sets latch 3 (idx=3, op=1) → s_out=8'h08 in cycles 1–2, all-zero in cycle 3, done_valid with done_id=0 and done_err=0 in cycle 4.
- All four requesters hold valid continuously → grant order 0,1,2,3,0. One grant every 4 cycles, never two ready bits high at once.
- Requester 2 sends reset to latch 5 right after a set to latch 5 → r_out=8'h20 while s_out=0, and S&R is never both high in any cycle.
- idx=7 with N_LATCH=6 → no S/R activity, done_err=1 at cycle 2.
- rst asserted during PULSE → s_out/r_out are 0 on the next edge and no done is produced. The next request goes to requester 0.
- With SR_LATCH_CTRL_VERIFY_EN defined, q_in is held at 0 during a set to latch 1 → done_err=1. With the correct q_in=1 → done_err=0.
